odd_even_sort_buffer: RTL and testbench

- Datapath stage controlled directly by the sort control FSM.
- Consumes the FSM's `load` (clear/arm fill) and `wd1` (start) strobes.
- Captures N words from an upstream stream and sorts them in place by odd-even transposition.
- Raises `full` back to the FSM when the sorted result is ready, then serves sorted words through an indexed read port to the downstream merge stage.

---
 rtl/sort_pkg.sv | 26 ++
 rtl/odd_even_sort_buffer_if.sv | 28 ++
 rtl/cmp_exchange.sv | 20 ++
 rtl/odd_even_sort_buffer.sv | 162 ++++++++++++++++
 tb/tb_odd_even_sort_buffer.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sort_pkg.sv
// Shared types and helpers for the odd-even transposition sort buffer.
// Build option: define ODD_EVEN_SORT_DESCEND_EN to sort in descending order.
package sort_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        SORT = 2'd2,
        DONE = 2'd3
    } sort_buf_state_t;

    localparam int SORT_N_DEFAULT = 8;
    localparam int SORT_W_DEFAULT = 8;

    // Operands are zero-extended to this width so one function serves any W up to it.
    localparam int CMP_W = 64;

    function automatic logic cmp_swap_f(input logic [CMP_W-1:0] a, input logic [CMP_W-1:0] b);
`ifdef ODD_EVEN_SORT_DESCEND_EN
        return a < b;
`else
        return a > b;
`endif
    endfunction

endpackage

// File: rtl/odd_even_sort_buffer_if.sv
// Stream-in and indexed read-out signals of the sort buffer.
interface odd_even_sort_buffer_if #(
    parameter int N  = 8,
    parameter int W  = 8,
    parameter int IW = $clog2(N)
) ();

    // Upstream handshake: a word transfers on a rising edge where in_valid && in_ready;
    // in_ready never waits on in_valid. Reads: rd_en is a request, dout/dout_valid follow one edge later.
    logic          in_valid;
    logic [W-1:0]  din;
    logic          in_ready;
    logic          rd_en;
    logic [IW-1:0] rd_idx;
    logic [W-1:0]  dout;
    logic          dout_valid;

    modport master (
        output in_valid, din, rd_en, rd_idx,
        input  in_ready, dout, dout_valid
    );

    modport slave (
        input  in_valid, din, rd_en, rd_idx,
        output in_ready, dout, dout_valid
    );

endinterface

// File: rtl/cmp_exchange.sv
// Two-input compare-and-swap; passes inputs straight through when disabled.
module cmp_exchange
    import sort_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         en,
    input  logic [W-1:0] x0,
    input  logic [W-1:0] x1,
    output logic [W-1:0] y0,
    output logic [W-1:0] y1
);

    logic swap;

    assign swap = en && cmp_swap_f(CMP_W'(x0), CMP_W'(x1));
    assign y0   = swap ? x1 : x0;
    assign y1   = swap ? x0 : x1;

endmodule

// File: rtl/odd_even_sort_buffer.sv
// Fills N words from a stream, sorts them in place by odd-even transposition
// (one phase per clock), then serves them by index. Order set by ODD_EVEN_SORT_DESCEND_EN.
module odd_even_sort_buffer
    import sort_pkg::*;
#(
    parameter int N  = SORT_N_DEFAULT,
    parameter int W  = SORT_W_DEFAULT,
    parameter int IW = $clog2(N)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic                     wd1,
    output logic                     full,
    odd_even_sort_buffer_if.slave    bus,
    output sort_buf_state_t          dbg_state,
    output logic [$clog2(N+1)-1:0]   dbg_count
);

    localparam int CW = $clog2(N + 1);
    localparam int PW = $clog2(N);

    sort_buf_state_t state;
    logic [CW-1:0]   count;
    logic [PW-1:0]   phase;
    logic            arm;
    logic            full_q;
    logic [W-1:0]    dout_q;
    logic            dout_valid_q;

    logic [W-1:0]    slot     [N];
    logic [W-1:0]    sort_nxt [N];
    logic [W-1:0]    pair_y0  [N-1];
    logic [W-1:0]    pair_y1  [N-1];
    logic [N-2:0]    pair_en;

    logic            in_ready;
    logic            wr_fire;
    logic [CW-1:0]   count_nxt;
    logic            fill_done;
    logic            last_phase;
    logic [W-1:0]    rd_data;

    assign in_ready   = (state == FILL) && (count < CW'(N));
    assign wr_fire    = in_ready && bus.in_valid;
    assign count_nxt  = count + CW'(wr_fire);
    // A write on the same edge counts towards completing the fill.
    assign fill_done  = (arm || wd1) && (count_nxt == CW'(N));
    assign last_phase = (phase == PW'(N - 1));

    // Pair i spans slots (i, i+1); even pairs run on even phases, odd pairs on odd phases.
    for (genvar i = 0; i < N - 1; i++) begin : g_pair
        assign pair_en[i] = (state == SORT) && (phase[0] == 1'(i % 2));

        cmp_exchange #(.W(W)) u_cmp (
            .en (pair_en[i]),
            .x0 (slot[i]),
            .x1 (slot[i+1]),
            .y0 (pair_y0[i]),
            .y1 (pair_y1[i])
        );
    end

    always_comb begin
        for (int j = 0; j < N; j++) begin
            sort_nxt[j] = slot[j];
        end
        for (int i = 0; i < N - 1; i++) begin
            if (pair_en[i]) begin
                sort_nxt[i]   = pair_y0[i];
                sort_nxt[i+1] = pair_y1[i];
            end
        end
    end

    // Out-of-range indices read as zero.
    always_comb begin
        rd_data = '0;
        for (int j = 0; j < N; j++) begin
            if (bus.rd_idx == IW'(j)) begin
                rd_data = slot[j];
            end
        end
    end

    // Storage carries no reset; its contents are meaningless until a fill completes.
    always_ff @(posedge clk) begin
        if (!reset && !load) begin
            if (wr_fire) begin
                for (int j = 0; j < N; j++) begin
                    if (count == CW'(j)) begin
                        slot[j] <= bus.din;
                    end
                end
            end else if (state == SORT) begin
                for (int j = 0; j < N; j++) begin
                    slot[j] <= sort_nxt[j];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            phase        <= '0;
            arm          <= 1'b0;
            full_q       <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else if (load) begin
            state        <= FILL;
            count        <= '0;
            phase        <= '0;
            arm          <= 1'b0;
            full_q       <= 1'b0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                end
                FILL: begin
                    count <= count_nxt;
                    if (wd1) begin
                        arm <= 1'b1;
                    end
                    if (fill_done) begin
                        state <= SORT;
                        phase <= '0;
                    end
                end
                SORT: begin
                    phase <= phase + PW'(1);
                    if (last_phase) begin
                        state  <= DONE;
                        phase  <= '0;
                        full_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.rd_en) begin
                        dout_q       <= rd_data;
                        dout_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign full           = full_q;
    assign bus.in_ready   = in_ready;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign dbg_state      = state;
    assign dbg_count      = count;

endmodule

// File: tb/tb_odd_even_sort_buffer.sv
// Directed bench for odd_even_sort_buffer at N=4, W=8; expected orders follow ODD_EVEN_SORT_DESCEND_EN.
module tb_odd_even_sort_buffer;
    import sort_pkg::*;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 3;
    localparam int CW = $clog2(N + 1);

    logic            clk;
    logic            reset;
    logic            load;
    logic            wd1;
    logic            full;
    sort_buf_state_t dbg_state;
    logic [CW-1:0]   dbg_count;

    odd_even_sort_buffer_if #(.N(N), .W(W), .IW(IW)) bus ();

    odd_even_sort_buffer #(.N(N), .W(W), .IW(IW)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .wd1       (wd1),
        .full      (full),
        .bus       (bus),
        .dbg_state (dbg_state),
        .dbg_count (dbg_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    logic [W-1:0] exp1 [N];
    logic [W-1:0] exp2 [N];
    logic [W-1:0] exp3 [N];
    logic [W-1:0] exp4 [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // driver tasks: inputs change 1 time unit after the edge, outputs are sampled there too
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load();
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic pulse_wd1();
        wd1 = 1'b1;
        tick();
        wd1 = 1'b0;
    endtask

    task automatic write_word(input logic [W-1:0] d, input logic with_wd1);
        bus.in_valid = 1'b1;
        bus.din      = d;
        wd1          = with_wd1;
        tick();
        bus.in_valid = 1'b0;
        wd1          = 1'b0;
    endtask

    // Called right after the edge that entered SORT: full must rise exactly N edges later.
    task automatic wait_sorted(input string tag);
        for (int i = 0; i < N - 1; i++) begin
            tick();
        end
        check({tag, "_full_early"}, 32'(full), 32'd0);
        tick();
        check({tag, "_full"}, 32'(full), 32'd1);
        check({tag, "_state_done"}, 32'(dbg_state), 32'(DONE));
    endtask

    task automatic read_slot(input string tag, input logic [IW-1:0] idx);
        logic [W-1:0] e;
        bus.rd_en  = 1'b1;
        bus.rd_idx = idx;
        tick();
        bus.rd_en  = 1'b0;
        e = exp_q.pop_front();
        check($sformatf("%s_vld%0d", tag, idx), 32'(bus.dout_valid), 32'd1);
        check($sformatf("%s_dout%0d", tag, idx), 32'(bus.dout), 32'(e));
    endtask

    task automatic read_all(input string tag, input logic [W-1:0] e [N]);
        for (int i = 0; i < N; i++) begin
            exp_q.push_back(e[i]);
        end
        for (int i = 0; i < N; i++) begin
            read_slot(tag, IW'(i));
        end
        tick();
        check({tag, "_vld_drop"}, 32'(bus.dout_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef ODD_EVEN_SORT_DESCEND_EN
        exp1 = '{8'd4, 8'd3, 8'd1, 8'd1};
        exp2 = '{8'd9, 8'd8, 8'd7, 8'd6};
        exp4 = '{8'd255, 8'd128, 8'd1, 8'd0};
`else
        exp1 = '{8'd1, 8'd1, 8'd3, 8'd4};
        exp2 = '{8'd6, 8'd7, 8'd8, 8'd9};
        exp4 = '{8'd0, 8'd1, 8'd128, 8'd255};
`endif
        exp3 = '{8'd2, 8'd2, 8'd2, 8'd2};

        reset        = 1'b1;
        load         = 1'b0;
        wd1          = 1'b0;
        bus.in_valid = 1'b0;
        bus.din      = '0;
        bus.rd_en    = 1'b0;
        bus.rd_idx   = '0;
        tick();
        tick();
        check("rst_full", 32'(full), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_dout", 32'(bus.dout), 32'd0);
        check("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_count", 32'(dbg_count), 32'd0);
        reset = 1'b0;

        // IDLE ignores stream and start strobe
        bus.in_valid = 1'b1;
        bus.din      = 8'h77;
        wd1          = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        wd1          = 1'b0;
        check("idle_state", 32'(dbg_state), 32'(IDLE));
        check("idle_in_ready", 32'(bus.in_ready), 32'd0);

        // scenario 1: arm before filling
        do_load();
        check("s1_state_fill", 32'(dbg_state), 32'(FILL));
        check("s1_in_ready", 32'(bus.in_ready), 32'd1);
        check("s1_count0", 32'(dbg_count), 32'd0);
        pulse_wd1();
        write_word(8'd3, 1'b0);
        write_word(8'd1, 1'b0);
        write_word(8'd4, 1'b0);
        write_word(8'd1, 1'b0);
        check("s1_state_sort", 32'(dbg_state), 32'(SORT));
        check("s1_in_ready_sort", 32'(bus.in_ready), 32'd0);
        wait_sorted("s1");
        read_all("s1", exp1);

        // scenario 2: fill without start, extra word dropped, late start
        do_load();
        write_word(8'd9, 1'b0);
        write_word(8'd8, 1'b0);
        write_word(8'd7, 1'b0);
        write_word(8'd6, 1'b0);
        check("s2_state_fill", 32'(dbg_state), 32'(FILL));
        check("s2_in_ready_full", 32'(bus.in_ready), 32'd0);
        check("s2_full_low", 32'(full), 32'd0);
        write_word(8'hAA, 1'b0);
        check("s2_count_held", 32'(dbg_count), 32'(N));
        check("s2_still_fill", 32'(dbg_state), 32'(FILL));
        pulse_wd1();
        check("s2_state_sort", 32'(dbg_state), 32'(SORT));
        wait_sorted("s2");
        read_all("s2", exp2);

        // scenario 3: load beats in_valid; start on the last write
        load         = 1'b1;
        bus.in_valid = 1'b1;
        bus.din      = 8'h55;
        tick();
        load         = 1'b0;
        bus.in_valid = 1'b0;
        check("s3_count0", 32'(dbg_count), 32'd0);
        check("s3_state_fill", 32'(dbg_state), 32'(FILL));
        write_word(8'd2, 1'b0);
        write_word(8'd2, 1'b0);
        write_word(8'd2, 1'b0);
        write_word(8'd2, 1'b1);
        check("s3_state_sort", 32'(dbg_state), 32'(SORT));
        wait_sorted("s3");
        read_all("s3", exp3);

        // scenario 4: abort during phase 1
        do_load();
        pulse_wd1();
        write_word(8'd5, 1'b0);
        write_word(8'd6, 1'b0);
        write_word(8'd7, 1'b0);
        write_word(8'd8, 1'b0);
        check("s4_state_sort", 32'(dbg_state), 32'(SORT));
        tick();
        do_load();
        check("s4_abort_full", 32'(full), 32'd0);
        check("s4_abort_state", 32'(dbg_state), 32'(FILL));
        check("s4_abort_count", 32'(dbg_count), 32'd0);
        bus.rd_en  = 1'b1;
        bus.rd_idx = '0;
        tick();
        bus.rd_en  = 1'b0;
        check("s4_rd_in_fill", 32'(bus.dout_valid), 32'd0);
        tick();
        tick();
        check("s4_full_stays_low", 32'(full), 32'd0);
        check("s4_state_stays", 32'(dbg_state), 32'(FILL));
        write_word(8'd0, 1'b0);
        write_word(8'd255, 1'b0);
        write_word(8'd128, 1'b0);
        write_word(8'd1, 1'b1);
        check("s4_state_sort2", 32'(dbg_state), 32'(SORT));
        wait_sorted("s4");
        read_all("s4", exp4);

        // scenario 5: out-of-range read, then reset while in DONE
        exp_q.push_back(8'd0);
        read_slot("s5_oob", IW'(5));
        bus.rd_en  = 1'b1;
        bus.rd_idx = '0;
        reset      = 1'b1;
        tick();
        reset      = 1'b0;
        bus.rd_en  = 1'b0;
        check("s5_full", 32'(full), 32'd0);
        check("s5_in_ready", 32'(bus.in_ready), 32'd0);
        check("s5_dout", 32'(bus.dout), 32'd0);
        check("s5_dout_valid", 32'(bus.dout_valid), 32'd0);
        check("s5_state", 32'(dbg_state), 32'(IDLE));
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        check("s5_rd_after_rst_vld", 32'(bus.dout_valid), 32'd0);
        check("s5_rd_after_rst_dout", 32'(bus.dout), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
